// File: rtl/proc_control.sv
// Multi-cycle control FSM for the 16-bit datapath: latches one instruction per run
// request and sequences bus-mux selects, register write enables and the A/G adder.
module proc_control #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [15:0]       instr,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] imediat,
  output logic              imediat_select,
  output logic              r0_select,
  output logic              r1_select,
  output logic              r2_select,
  output logic              r3_select,
  output logic              r4_select,
  output logic              r5_select,
  output logic              r6_select,
  output logic              r7_select,
  output logic              r_select,
  output logic [7:0]        r_in,
  output logic              a_in,
  output logic              g_in,
  output logic              addsub
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StT1   = 2'd1;
  localparam logic [1:0] StT2   = 2'd2;
  localparam logic [1:0] StT3   = 2'd3;

  localparam logic [1:0] OpMv  = 2'b00;
  localparam logic [1:0] OpMvi = 2'b01;

  logic [1:0]  state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] op;
  logic [2:0] rx;
  logic [2:0] ry;
  logic [8:0] imm9;
  logic       op_arith;
  logic [7:0] rx_onehot;
  logic [7:0] ry_onehot;
  logic [7:0] reg_sel;

  assign op        = ir_q[15:13];
  assign rx        = ir_q[12:10];
  assign ry        = ir_q[9:7];
  assign imm9      = ir_q[8:0];
  assign op_arith  = (op[2:1] == 2'b01);
  assign rx_onehot = 8'd1 << rx;
  assign ry_onehot = 8'd1 << ry;

  // Next-state and IR capture; run is only looked at in idle, so it is never queued.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StT1;
          ir_d    = instr;
        end
      end
      StT1:    state_d = op_arith ? StT2 : StIdle;
      StT2:    state_d = StT3;
      StT3:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Moore decode from state and IR only; every bus source stays low in idle.
  always_comb begin
    done           = 1'b0;
    illegal        = 1'b0;
    imediat_select = 1'b0;
    r_select       = 1'b0;
    reg_sel        = '0;
    r_in           = '0;
    a_in           = 1'b0;
    g_in           = 1'b0;
    addsub         = 1'b0;
    case (state_q)
      StT1: begin
        if (op[2]) begin
          done    = 1'b1;
          illegal = 1'b1;
        end else begin
          unique case (op[1:0])
            OpMv: begin
              reg_sel = ry_onehot;
              r_in    = rx_onehot;
              done    = 1'b1;
            end
            OpMvi: begin
              imediat_select = 1'b1;
              r_in           = rx_onehot;
              done           = 1'b1;
            end
            default: begin
              reg_sel = rx_onehot;
              a_in    = 1'b1;
            end
          endcase
        end
      end
      StT2: begin
        reg_sel = ry_onehot;
        g_in    = 1'b1;
        addsub  = op[0];
      end
      StT3: begin
        r_select = 1'b1;
        r_in     = rx_onehot;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign imediat   = {{(DATA_W-9){imm9[8]}}, imm9};
  assign r0_select = reg_sel[0];
  assign r1_select = reg_sel[1];
  assign r2_select = reg_sel[2];
  assign r3_select = reg_sel[3];
  assign r4_select = reg_sel[4];
  assign r5_select = reg_sel[5];
  assign r6_select = reg_sel[6];
  assign r7_select = reg_sel[7];

endmodule

// File: tb/tb_proc_control.sv
// Randomized bench for proc_control: per-cycle expected-output queue plus a register-level
// datapath driven by the DUT, compared against plain-arithmetic instruction results.
module tb_proc_control;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] instr;
  logic        busy, done, illegal;
  logic [15:0] imediat;
  logic        imediat_select, r_select;
  logic        r0_select, r1_select, r2_select, r3_select;
  logic        r4_select, r5_select, r6_select, r7_select;
  logic [7:0]  r_in;
  logic        a_in, g_in, addsub;

  proc_control #(.DATA_W(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .run            (run),
    .instr          (instr),
    .busy           (busy),
    .done           (done),
    .illegal        (illegal),
    .imediat        (imediat),
    .imediat_select (imediat_select),
    .r0_select      (r0_select),
    .r1_select      (r1_select),
    .r2_select      (r2_select),
    .r3_select      (r3_select),
    .r4_select      (r4_select),
    .r5_select      (r5_select),
    .r6_select      (r6_select),
    .r7_select      (r7_select),
    .r_select       (r_select),
    .r_in           (r_in),
    .a_in           (a_in),
    .g_in           (g_in),
    .addsub         (addsub)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       done;
    logic       illegal;
    logic       imsel;
    logic       rsel;
    logic [7:0] regsel;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
  } step_t;

  step_t       exp_q[$];
  logic [15:0] ir_m;
  logic [15:0] cur_ins;
  logic [15:0] ref_regs[8];
  logic [15:0] dp_regs[8];
  logic [15:0] dp_a, dp_g;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic logic [127:0] pack_regs(input logic [15:0] r[8]);
    logic [127:0] p = '0;
    for (int i = 0; i < 8; i++) p[i*16 +: 16] = r[i];
    return p;
  endfunction

  // Expected cycle-by-cycle outputs of one instruction, from the opcode table.
  task automatic push_instr(input logic [15:0] ins);
    step_t      s;
    logic [7:0] one = 8'd1;
    logic [2:0] op = ins[15:13];
    logic [7:0] rxh = one << ins[12:10];
    logic [7:0] ryh = one << ins[9:7];
    s = '0;
    if (op[2]) begin
      s.done = 1'b1; s.illegal = 1'b1; exp_q.push_back(s);
    end else if (op == 3'd0) begin
      s.regsel = ryh; s.rin = rxh; s.done = 1'b1; exp_q.push_back(s);
    end else if (op == 3'd1) begin
      s.imsel = 1'b1; s.rin = rxh; s.done = 1'b1; exp_q.push_back(s);
    end else begin
      s.regsel = rxh; s.ain = 1'b1; exp_q.push_back(s);
      s = '0; s.regsel = ryh; s.gin = 1'b1; s.addsub = op[0]; exp_q.push_back(s);
      s = '0; s.rsel = 1'b1; s.rin = rxh; s.done = 1'b1; exp_q.push_back(s);
    end
  endtask

  task automatic apply_ref(input logic [15:0] ins);
    int unsigned rx = 32'(ins[12:10]);
    int unsigned ry = 32'(ins[9:7]);
    case (ins[15:13])
      3'd0:    ref_regs[rx] = ref_regs[ry];
      3'd1:    ref_regs[rx] = sext9(ins[8:0]);
      3'd2:    ref_regs[rx] = ref_regs[rx] + ref_regs[ry];
      3'd3:    ref_regs[rx] = ref_regs[rx] - ref_regs[ry];
      default: ;
    endcase
  endtask

  // Check the current cycle, then drive inputs for the next rising edge.
  task automatic step(input logic rst, input logic rn, input logic [15:0] ins);
    step_t       e;
    logic [7:0]  sel;
    logic [15:0] bus;
    logic        active;
    @(negedge clock);
    active = (exp_q.size() != 0);
    e = active ? exp_q[0] : '0;
    sel = {r7_select, r6_select, r5_select, r4_select,
           r3_select, r2_select, r1_select, r0_select};
    check_eq("outputs", 128'({busy, done, illegal, imediat_select, r_select, sel, r_in,
                              a_in, g_in, addsub}), 128'({active, e}));
    check_eq("imediat", 128'(imediat), 128'(sext9(ir_m[8:0])));
    check_eq("sel_onehot", 128'($onehot0({imediat_select, r_select, sel})), 128'(1));
    bus = '0;
    if (imediat_select) bus = imediat;
    if (r_select) bus = dp_g;
    for (int i = 0; i < 8; i++) if (sel[i]) bus = dp_regs[i];
    if (!active) check_eq("idle_bus", 128'(bus), 128'(0));
    if (g_in) dp_g = addsub ? dp_a - bus : dp_a + bus;
    if (a_in) dp_a = bus;
    for (int i = 0; i < 8; i++) if (r_in[i]) dp_regs[i] = bus;
    reset = rst;
    run   = rn;
    instr = ins;
    if (active) begin
      if (exp_q.size() == 1) begin
        apply_ref(cur_ins);
        check_eq("regfile", pack_regs(dp_regs), pack_regs(ref_regs));
      end
      if (rst) exp_q.delete();
      else void'(exp_q.pop_front());
    end else if (!rst && rn) begin
      ir_m    = ins;
      cur_ins = ins;
      push_instr(ins);
    end
    if (rst) ir_m = '0;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w = 16'($urandom);
    if ($urandom_range(0, 9) < 8) w[15] = 1'b0;
    return w;
  endfunction

  initial begin
    reset = 1'b1;
    run   = 1'b0;
    instr = '0;
    ir_m  = '0;
    cur_ins = '0;
    dp_a = '0;
    dp_g = '0;
    for (int i = 0; i < 8; i++) begin
      ref_regs[i] = 16'($urandom);
      dp_regs[i]  = ref_regs[i];
    end
    repeat (2) @(posedge clock);

    // mvi r3,#0x1FF
    step(1'b0, 1'b1, 16'h2DFF);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    // add r1,r2 then sub r1,r2
    step(1'b0, 1'b1, 16'h4500);
    repeat (4) step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h6500);
    repeat (4) step(1'b0, 1'b0, 16'h0000);
    // run pulsed during T2 of an add is ignored
    step(1'b0, 1'b1, 16'h4500);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h2DFF);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    // illegal opcode
    step(1'b0, 1'b1, 16'hE000);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    // reset in T2 of sub, then mv r0,r7
    step(1'b0, 1'b1, 16'h6500);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 16'h0380);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    // rx==ry: add r4,r4 and sub r5,r5, issued back-to-back with run held high
    step(1'b0, 1'b1, 16'h5200);
    repeat (3) step(1'b0, 1'b1, 16'h5200);
    step(1'b0, 1'b1, 16'h7680);
    repeat (3) step(1'b0, 1'b0, 16'h0000);

    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), rand_instr());
    end
    repeat (4) step(1'b0, 1'b0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
